reset_counter: RTL and testbench
================================

RESET_COUNTER -- requirements
Module: reset_counter

Interface
REQ-001 SHALL have parameter CNT_DIV (default 64): terminal count used when i_clk_div_ratio=1 (i_clk is the 8x-divided sideband clock).
REQ-002 SHALL have parameter CNT_NODIV (default 512): terminal count used when i_clk_div_ratio=0 (i_clk is undivided); SHALL satisfy CNT_NODIV >= CNT_DIV >= 2.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port i_count_en, input, 1 bit: level request to run the reset-duration timer; low clears the timer.
REQ-007 SHALL have port i_clk_div_ratio, input, 1 bit: 1 selects CNT_DIV, 0 selects CNT_NODIV.
REQ-008 SHALL have port o_reset_count_done, output, 1 bit, registered: high once the selected duration has elapsed with i_count_en held high.

Function
REQ-009 SHALL implement FSM states IDLE, COUNTING, DONE.
REQ-010 IDLE: counter=0, done=0; on an edge sampling i_count_en=1, go to COUNTING, set counter=1, latch i_clk_div_ratio into an internal terminal-select register.
REQ-011 COUNTING: on each edge with i_count_en=1, counter increments; on the edge where counter==N-1 (N = latched terminal), go to DONE and set o_reset_count_done=1.
REQ-012 o_reset_count_done therefore SHALL rise exactly N rising edges after (and including) the first edge sampling i_count_en=1.
REQ-013 DONE: o_reset_count_done SHALL stay 1 while i_count_en=1; counter SHALL hold (no wrap, no further increment).
REQ-014 In COUNTING or DONE, an edge sampling i_count_en=0 SHALL return to IDLE, clear counter, and drive o_reset_count_done=0 from that edge.
REQ-015 Changes of i_clk_div_ratio after the IDLE->COUNTING transition SHALL be ignored until the next return to IDLE.
REQ-016 Re-asserting i_count_en after a drop SHALL restart a full N-cycle count from 1.
REQ-017 Counter width SHALL be $clog2(max(CNT_DIV,CNT_NODIV)+1) bits; it SHALL never overflow.
REQ-018 o_reset_count_done SHALL be glitch-free (flop output, no combinational path from inputs).

Reset
REQ-019 On an edge with i_rst=1: state=IDLE, counter=0, latched ratio=1, o_reset_count_done=0; reset SHALL take priority over i_count_en.
REQ-020 Reset asserted mid-count or in DONE SHALL abort; after release, counting SHALL begin only on the first edge sampling i_count_en=1.

Structure
REQ-021 A shared package SHALL hold the FSM state enum (IDLE, COUNTING, DONE) and the default terminal-count constants (64, 512).
REQ-022 The block SHALL be a single module with no sub-module; counter, terminal mux and FSM are local.

Verification
REQ-023 Reset held 3 cycles, i_count_en=0 -> o_reset_count_done=0 throughout, counter=0.
REQ-024 i_clk_div_ratio=1, i_count_en rises and stays high -> done rises exactly 64 edges after the first sampling edge; i_count_en dropped 3 cycles later -> done=0 on that edge.
REQ-025 i_clk_div_ratio=0, i_count_en held high -> done after exactly 512 edges; ratio toggled to 1 at edge 10 -> still 512.
REQ-026 i_count_en dropped at edge 40 of a 64 count, re-raised 2 cycles later -> no done at edge 64; done 64 edges after re-raise.
REQ-027 i_rst pulsed for one cycle during DONE with i_count_en=1 -> done=0 on that edge, then a fresh 64-cycle count and done re-asserts.
REQ-028 i_count_en held high 200 cycles past done -> done stays 1, no wrap or drop.

Source files
------------

// File: rtl/reset_counter_pkg.sv
// Shared definitions for the reset-duration timer: FSM state encoding and
// the default terminal counts for divided / undivided sideband clocks.
package reset_counter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DONE     = 2'd2
  } state_e;

  localparam int CNT_DIV_DEFAULT   = 64;
  localparam int CNT_NODIV_DEFAULT = 512;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_counter.sv
// Reset-duration timer: counts consecutive clock edges with i_count_en high
// and raises a registered done flag after the selected terminal count.
module reset_counter
  import reset_counter_pkg::*;
#(
  parameter int CNT_DIV   = CNT_DIV_DEFAULT,
  parameter int CNT_NODIV = CNT_NODIV_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_count_en,
  input  logic i_clk_div_ratio,
  output logic o_reset_count_done
);

  localparam int CNT_MAX = maxInt(CNT_DIV, CNT_NODIV);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TERM_DIV_LAST   = CW'(CNT_DIV - 1);
  localparam logic [CW-1:0] TERM_NODIV_LAST = CW'(CNT_NODIV - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic          termSel_q, termSel_d;
  logic          done_q, done_d;
  logic [CW-1:0] termLast;

  // Terminal select is latched on entry to COUNTING so mid-count ratio changes are ignored.
  assign termLast = termSel_q ? TERM_DIV_LAST : TERM_NODIV_LAST;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    termSel_d = termSel_q;
    done_d    = done_q;
    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        done_d    = 1'b0;
        if (i_count_en) begin
          state_d   = COUNTING;
          counter_d = CW'(1);
          termSel_d = i_clk_div_ratio;
        end
      end
      COUNTING: begin
        if (!i_count_en) begin
          state_d   = IDLE;
          counter_d = '0;
          done_d    = 1'b0;
        end else begin
          counter_d = counter_q + CW'(1);
          if (counter_q == termLast) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (!i_count_en) begin
          state_d   = IDLE;
          counter_d = '0;
          done_d    = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
        done_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      termSel_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      termSel_q <= termSel_d;
      done_q    <= done_d;
    end
  end

  assign o_reset_count_done = done_q;

endmodule

// File: tb/tb_reset_counter.sv
// Self-checking bench for reset_counter: directed scenarios plus random bursts,
// compared each edge against a run-length model of the enable input.
module tb_reset_counter;

  logic clk = 1'b0;
  logic rstI = 1'b1;
  logic countEnI = 1'b0;
  logic divRatioI = 1'b1;
  logic doneO;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: length of the current unbroken run of enabled edges and
  // the terminal count chosen when that run began.
  int  runLen = 0;
  int  runTerm = 64;
  logic expDone = 1'b0;

  reset_counter dut (
    .i_clk              (clk),
    .i_rst              (rstI),
    .i_count_en         (countEnI),
    .i_clk_div_ratio    (divRatioI),
    .o_reset_count_done (doneO)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input logic rst, input logic en, input logic ratio);
    if (rst || !en) begin
      runLen = 0;
    end else begin
      if (runLen == 0) runTerm = ratio ? 64 : 512;
      if (runLen < 100000) runLen = runLen + 1;
    end
    expDone = (runLen >= runTerm);
  endtask

  task automatic checkOutput(input string tag);
    vectors++;
    assert (doneO === expDone) else begin
      miscompares++;
      $error("FAIL %s: done=%b expected %b (run=%0d term=%0d)", tag, doneO, expDone, runLen, runTerm);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic ratio, input string tag);
    rstI      = rst;
    countEnI  = en;
    divRatioI = ratio;
    @(posedge clk);
    modelStep(rst, en, ratio);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    $display("[TB] reset_counter bench start");

    // Reset held three cycles with enable low, then idle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, "reset_hold");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, "idle_after_reset");

    // Divided clock: done on edge 64, held 3 cycles, then dropped.
    for (int i = 0; i < 67; i++) applyStimulus(1'b0, 1'b1, 1'b1, "div_count");
    applyStimulus(1'b0, 1'b0, 1'b1, "div_drop");
    applyStimulus(1'b0, 1'b0, 1'b1, "div_idle");

    // Undivided clock, ratio toggled at edge 10 must not shorten the count.
    for (int i = 1; i <= 515; i++)
      applyStimulus(1'b0, 1'b1, (i >= 10) ? 1'b1 : 1'b0, "nodiv_count");
    applyStimulus(1'b0, 1'b0, 1'b1, "nodiv_drop");

    // Drop at edge 40, re-raise two cycles later: full restart.
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b1, "abort_first");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, "abort_gap");
    for (int i = 0; i < 66; i++) applyStimulus(1'b0, 1'b1, 1'b1, "abort_restart");

    // Reset pulse during DONE with enable held: fresh count afterwards.
    applyStimulus(1'b1, 1'b1, 1'b1, "rst_in_done");
    for (int i = 0; i < 66; i++) applyStimulus(1'b0, 1'b1, 1'b1, "post_rst_count");

    // Long hold past done: no wrap, no drop.
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b1, 1'b0, "long_hold");
    applyStimulus(1'b0, 1'b0, 1'b1, "long_drop");

    // Reset mid-count, then count resumes only when enable is sampled high.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, "mid_count");
    applyStimulus(1'b1, 1'b1, 1'b1, "rst_mid_count");
    applyStimulus(1'b0, 1'b0, 1'b0, "post_rst_idle");
    for (int i = 0; i < 65; i++) applyStimulus(1'b0, 1'b1, 1'b1, "post_rst_restart");

    // Random bursts with jittering ratio and occasional resets.
    for (int b = 0; b < 24; b++) begin
      int burst;
      burst = $urandom_range(1, 560);
      for (int i = 0; i < burst; i++) begin
        logic r;
        logic e;
        r = ($urandom_range(0, 299) == 0);
        e = ($urandom_range(0, 199) != 0);
        applyStimulus(r, e, 1'($urandom_range(0, 1)), "random_burst");
      end
      for (int i = 0; i < $urandom_range(1, 3); i++)
        applyStimulus(1'($urandom_range(0, 3) == 0), 1'b0, 1'($urandom_range(0, 1)), "random_gap");
    end

    $display("[TB] reset_counter bench end");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
